// File: rtl/wam_pkg.sv
// Shared constants, state encoding and helpers for the Whack-A-Mole game core.
package wam_pkg;

  localparam int NUM_HOLES = 9;
  localparam int KEY_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [3:0] count_ones(input logic [NUM_HOLES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/wam_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick spawn holes.
module wam_lfsr
  import wam_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/wam_game_core.sv
// Whack-A-Mole round engine: spawns and ages moles, judges key events,
// keeps score/misses and the round timer.
module wam_game_core
  import wam_pkg::*;
#(
  parameter int         MOLE_LIFE  = 60,
  parameter int         SPAWN_GAP  = 20,
  parameter int         GAME_TICKS = 1800,
  parameter int         MAX_ACTIVE = 3,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 valid_key,
  input  logic [KEY_W-1:0]     key,
  output logic [NUM_HOLES-1:0] moles,
  output logic [7:0]           score,
  output logic [7:0]           misses,
  output logic [15:0]          time_left,
  output logic                 playing,
  output logic                 game_over,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);

  localparam logic [7:0]  LIFE_INIT = 8'(MOLE_LIFE);
  localparam logic [7:0]  GAP_INIT  = 8'(SPAWN_GAP);
  localparam logic [15:0] GAME_INIT = 16'(GAME_TICKS);
  localparam logic [3:0]  MAX_UP    = 4'(MAX_ACTIVE);
  localparam logic [NUM_HOLES-1:0] ONE_HOT0 = {{(NUM_HOLES-1){1'b0}}, 1'b1};

  state_t state, state_next;

  logic [7:0]           lfsr;
  logic                 unused_lfsr_hi;
  logic [3:0]           cand;
  logic                 valid_key_q;
  logic [KEY_W-1:0]     key_q;
  logic [7:0]           spawn_cnt;
  logic                 in_play, play_tick, start_round, round_end, clear_all;
  logic                 key_event, key_ok, whiff, spawn_try, spawn_ok;
  logic [NUM_HOLES-1:0] hit_vec, spawn_vec, escape_vec;
  logic [3:0]           escape_cnt;
  logic [8:0]           miss_sum;

  wam_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[7:4];
  assign cand = (lfsr[3:0] >= 4'd9) ? (lfsr[3:0] - 4'd9) : lfsr[3:0];

  assign in_play     = (state == PLAY);
  assign play_tick   = in_play & tick;
  assign start_round = (state != PLAY) & start;
  assign round_end   = play_tick & (time_left == 16'd1);
  assign clear_all   = start_round | round_end;

  // A new event is a rising valid or a change of key while valid stays high.
  assign key_event = valid_key & (~valid_key_q | (key != key_q));
  assign key_ok    = in_play & key_event & (key <= 4'd8);
  assign hit_vec   = key_ok ? (moles & (ONE_HOT0 << key)) : '0;
  assign whiff     = key_ok & ~(|hit_vec);

  // Spawn decisions look only at pre-edge moles, so a hole being hit is never a target.
  assign spawn_try = play_tick & (spawn_cnt <= 8'd1);
  assign spawn_ok  = spawn_try & ~moles[cand] & (count_ones(moles) < MAX_UP);
  assign spawn_vec = spawn_ok ? (ONE_HOT0 << cand) : '0;

  assign escape_cnt = count_ones(escape_vec);
  assign miss_sum   = {1'b0, misses} + {5'd0, escape_cnt} + {8'd0, whiff};

  for (genvar i = 0; i < NUM_HOLES; i++) begin : g_hole
    logic       up;
    logic [7:0] life;

    assign moles[i]      = up;
    assign escape_vec[i] = play_tick & up & (life == 8'd1) & ~hit_vec[i];

    always_ff @(posedge clk) begin
      if (reset || clear_all || hit_vec[i]) begin
        up   <= 1'b0;
        life <= '0;
      end else if (spawn_vec[i]) begin
        up   <= 1'b1;
        life <= LIFE_INIT;
      end else if (play_tick && up) begin
        life <= life - 8'd1;
        if (life == 8'd1) up <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, OVER: if (start) state_next = PLAY;
      PLAY:       if (round_end) state_next = OVER;
      default:    state_next = IDLE;
    endcase
  end

  assign playing   = (state == PLAY);
  assign game_over = (state == OVER);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_key_q <= 1'b0;
      key_q       <= '0;
      score       <= '0;
      misses      <= '0;
      time_left   <= '0;
      spawn_cnt   <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
    end else begin
      valid_key_q <= valid_key;
      key_q       <= key;
      hit_pulse   <= |hit_vec;
      miss_pulse  <= (|escape_vec) | whiff;
      if (start_round) begin
        score     <= '0;
        misses    <= '0;
        time_left <= GAME_INIT;
        spawn_cnt <= GAP_INIT;
      end else if (in_play) begin
        if ((|hit_vec) && (score != 8'hFF)) score <= score + 8'd1;
        misses <= (miss_sum > 9'd255) ? 8'hFF : miss_sum[7:0];
        if (play_tick) begin
          time_left <= time_left - 16'd1;
          spawn_cnt <= spawn_try ? GAP_INIT : (spawn_cnt - 8'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wam_game_core.sv
// Directed plus randomized bench for wam_game_core with a round-level reference model.
module tb_wam_game_core;

  localparam int         MOLE_LIFE  = 3;
  localparam int         SPAWN_GAP  = 2;
  localparam int         GAME_TICKS = 12;
  localparam int         MAX_ACTIVE = 2;
  localparam logic [7:0] SEED       = 8'hA5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        tick = 1'b0, start = 1'b0, valid_key = 1'b0;
  logic [3:0]  key = '0;
  logic [8:0]  moles;
  logic [7:0]  score, misses;
  logic [15:0] time_left;
  logic        playing, game_over, hit_pulse, miss_pulse;

  wam_game_core #(
    .MOLE_LIFE (MOLE_LIFE), .SPAWN_GAP (SPAWN_GAP), .GAME_TICKS(GAME_TICKS),
    .MAX_ACTIVE(MAX_ACTIVE), .LFSR_SEED (SEED)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .valid_key(valid_key), .key(key),
    .moles(moles), .score(score), .misses(misses), .time_left(time_left),
    .playing(playing), .game_over(game_over), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  // reference model: a mole is up exactly while it has remaining life
  int       m_phase;  // 0 idle, 1 in round, 2 round finished
  bit [7:0] m_lfsr;
  int       m_life[9];
  int       m_score, m_misses, m_time, m_spawn, m_keyq;
  bit       m_vkq, m_hitp, m_missp;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_step(input bit rst, input bit st, input bit tk, input bit vk, input int k);
    int c, esc, hit, whiff, cnt;
    bit ev;
    bit up0[9];
    if (rst) begin
      m_phase = 0; m_lfsr = SEED;
      foreach (m_life[i]) m_life[i] = 0;
      m_score = 0; m_misses = 0; m_time = 0; m_spawn = 0;
      m_vkq = 0; m_keyq = 0; m_hitp = 0; m_missp = 0;
      return;
    end
    ev = vk && (!m_vkq || k != m_keyq);
    m_vkq = vk; m_keyq = k;
    c = int'(m_lfsr) % 16;
    if (c >= 9) c -= 9;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_hitp = 0; m_missp = 0;
    if (m_phase != 1) begin
      if (st) begin
        m_phase = 1; m_score = 0; m_misses = 0;
        foreach (m_life[i]) m_life[i] = 0;
        m_time = GAME_TICKS; m_spawn = SPAWN_GAP;
      end
      return;
    end
    cnt = 0;
    foreach (m_life[i]) begin
      up0[i] = m_life[i] > 0;
      if (up0[i]) cnt++;
    end
    hit = 0; whiff = 0; esc = 0;
    if (ev && k <= 8) begin
      if (up0[k]) hit = 1;
      else whiff = 1;
    end
    if (hit) m_life[k] = 0;
    if (tk) begin
      foreach (m_life[i]) begin
        if (up0[i] && !(hit && i == k)) begin
          m_life[i]--;
          if (m_life[i] == 0) esc++;
        end
      end
      m_spawn--;
      if (m_spawn == 0) begin
        m_spawn = SPAWN_GAP;
        if (!up0[c] && cnt < MAX_ACTIVE) m_life[c] = MOLE_LIFE;
      end
      m_time--;
      if (m_time == 0) begin
        m_phase = 2;
        foreach (m_life[i]) m_life[i] = 0;
      end
    end
    m_score  = (m_score + hit > 255) ? 255 : m_score + hit;
    m_misses = (m_misses + esc + whiff > 255) ? 255 : m_misses + esc + whiff;
    m_hitp   = (hit != 0);
    m_missp  = (esc + whiff) != 0;
  endtask

  function automatic logic [8:0] model_moles();
    logic [8:0] v;
    foreach (m_life[i]) v[i] = (m_life[i] > 0);
    return v;
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int up_n;
    chk("moles",      16'(moles),      16'(model_moles()));
    chk("score",      16'(score),      16'(m_score));
    chk("misses",     16'(misses),     16'(m_misses));
    chk("time_left",  time_left,       16'(m_time));
    chk("playing",    16'(playing),    16'(m_phase == 1));
    chk("game_over",  16'(game_over),  16'(m_phase == 2));
    chk("hit_pulse",  16'(hit_pulse),  16'(m_hitp));
    chk("miss_pulse", 16'(miss_pulse), 16'(m_missp));
    up_n = 0;
    for (int i = 0; i < 9; i++) up_n += int'(moles[i]);
    chk("max_active", 16'(up_n <= MAX_ACTIVE), 16'd1);
  endtask

  // driver: apply inputs, advance model, clock, compare #1 after the edge
  task automatic step(input bit rst, input bit st, input bit tk, input bit vk, input logic [3:0] k);
    reset = rst; start = st; tick = tk; valid_key = vk; key = k;
    model_step(rst, st, tk, vk, int'(k));
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int h, e, m0, guard;
    int ups[$];
    bit rst, st, tk, vk;
    logic [3:0] k;

    step(1, 0, 0, 0, 4'd0);
    step(1, 0, 0, 0, 4'd0);
    chk("reset_moles", 16'(moles), 16'd0);
    chk("reset_time",  time_left,  16'd0);
    chk("reset_idle",  16'(playing | game_over), 16'd0);

    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 4'(i));
    chk("idle_ignores_keys", 16'(misses), 16'd0);

    step(0, 1, 0, 0, 4'd0);
    chk("start_playing", 16'(playing), 16'd1);
    chk("start_time",    time_left,    16'(GAME_TICKS));
    chk("start_score",   16'(score),   16'd0);

    guard = 0;
    while (model_moles() == 9'd0 && guard < 20) begin
      step(0, 0, 1, 0, 4'd0);
      guard++;
    end
    chk("spawn_seen", 16'(moles != 9'd0), 16'd1);
    h = 0;
    for (int i = 8; i >= 0; i--) if (m_life[i] > 0) h = i;
    step(0, 0, 0, 1, 4'(h));
    chk("first_hit_score", 16'(score),     16'd1);
    chk("first_hit_pulse", 16'(hit_pulse), 16'd1);
    step(0, 0, 0, 1, 4'(h));
    chk("held_key_no_rehit", 16'(score),     16'd1);
    chk("hit_pulse_one_clk", 16'(hit_pulse), 16'd0);

    e = 0;
    for (int i = 8; i >= 0; i--) if (m_life[i] == 0) e = i;
    step(0, 0, 0, 0, 4'd0);
    m0 = m_misses;
    step(0, 0, 0, 1, 4'(e));
    chk("whiff_counts", 16'(misses), 16'(m0 + 1));
    step(0, 0, 0, 0, 4'd0);
    step(0, 0, 0, 1, 4'd12);
    chk("invalid_key_ignored", 16'(misses), 16'(m0 + 1));

    guard = 0;
    while (m_phase == 1 && guard < 100) begin
      step(0, 0, 1, 0, 4'd0);
      guard++;
    end
    chk("round_end_over",  16'(game_over), 16'd1);
    chk("round_end_moles", 16'(moles),     16'd0);
    chk("round_end_time",  time_left,      16'd0);
    chk("round_end_score", 16'(score),     16'd1);

    step(0, 1, 1, 0, 4'd0);
    chk("restart_score", 16'(score),  16'd0);
    chk("restart_time",  time_left,   16'(GAME_TICKS));

    for (int i = 0; i < 300; i++) step(0, 0, 0, 1, (i % 2 == 0) ? 4'd7 : 4'd8);
    chk("misses_saturate", 16'(misses), 16'd255);

    step(0, 0, 1, 0, 4'd0);
    step(1, 0, 0, 0, 4'd0);
    chk("mid_round_reset_play",   16'(playing), 16'd0);
    chk("mid_round_reset_misses", 16'(misses),  16'd0);
    chk("mid_round_reset_time",   time_left,    16'd0);

    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 999) == 0);
      st  = ($urandom_range(0, 39) == 0);
      tk  = ($urandom_range(0, 2) == 0);
      vk  = ($urandom_range(0, 3) != 0);
      ups.delete();
      foreach (m_life[i]) if (m_life[i] > 0) ups.push_back(i);
      if (ups.size() > 0 && $urandom_range(0, 1) == 1)
        k = 4'(ups[$urandom_range(0, ups.size() - 1)]);
      else
        k = 4'($urandom_range(0, 15));
      step(rst, st, tk, vk, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wam_game_core.md
Name: wam_game_core

Overview:
- Consumes debounced key events (valid_key, key 0-8) from the keypad controller and runs the Whack-A-Mole round.
- Raises moles in 9 holes at pseudo-random positions and ages each mole with a per-hole lifetime counter.
- Judges each key event as a hit or a whiff, and keeps score, misses and the round timer.
- Drives hole LEDs and score/timer state for the display stage downstream.

Parameters:
- MOLE_LIFE, 60: ticks a mole stays up before escaping (1..255).
- SPAWN_GAP, 20: ticks between spawn attempts (1..255).
- GAME_TICKS, 1800: round length in ticks (1..65535).
- MAX_ACTIVE, 3: maximum simultaneously raised moles (1..9).
- LFSR_SEED, 8'hA5: LFSR reset value, nonzero.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; the only reset
- tick  in  1  one-cycle game-time strobe from the time base
- start  in  1  request to begin a round (level, sampled each clk)
- valid_key  in  1  keypad controller key-valid level
- key  in  4  keypad position 0-8; values 9-15 are invalid
- moles  out  9  bit i high = mole up in hole i
- score  out  8  hits, saturating at 255
- misses  out  8  escapes + whiffs, saturating at 255
- time_left  out  16  remaining round ticks
- playing  out  1  FSM in PLAY
- game_over  out  1  FSM in OVER
- hit_pulse  out  1  one cycle per hit
- miss_pulse  out  1  one cycle per cycle with ≥1 escape or whiff

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (reset). All state updates on the rising edge of clk.
- Reset values: moles=0, score=0, misses=0, time_left=0, pulses=0, FSM=IDLE, LFSR=LFSR_SEED, all hole and spawn counters=0, key history cleared. Reset mid-round aborts the round immediately.
- FSM states: IDLE, PLAY, OVER.
  - IDLE or OVER with start=1 -> PLAY. On this transition: score=0, misses=0, moles=0, time_left=GAME_TICKS, spawn counter=SPAWN_GAP.
  - start while in PLAY is ignored.
  - PLAY with tick=1 and time_left==1 -> OVER. time_left becomes 0 and moles are cleared in that same cycle. score and misses hold.
- LFSR: 8-bit maximal-length, taps x^8+x^6+x^5+x^4+1. Advances every clk in every state so spawn positions depend on player timing.
- Candidate hole: c=lfsr[3:0]; if c≥9 then c=c-9.
- Spawn (PLAY only): on tick, the spawn counter decrements. On reaching 0 it reloads SPAWN_GAP and attempts a spawn.
  - The attempt raises hole c and loads its life counter with MOLE_LIFE.
  - The attempt is skipped, with no retry, if hole c is already up, or popcount(moles)≥MAX_ACTIVE, judged on pre-edge state.
- Ageing: on tick, every up hole's life counter decrements. A counter reaching 0 lowers that mole and counts one escape. Multiple escapes in one tick each count.
- Key event: event = valid_key & (~valid_key_q | key≠key_q), where valid_key_q/key_q are registered copies. Events with key>8, or outside PLAY, are discarded.
- Judging an event (PLAY):
  - Hole key up -> hit: hole lowered, score+1 (saturating), hit_pulse=1 next cycle.
  - Hole key down -> whiff: misses+1.
- misses per cycle: misses += escapes + whiff, clamped at 255. miss_pulse=1 if that sum is nonzero.
- Latency: an event sampled at edge N is reflected in moles/score/pulses after edge N (one-cycle registered).
- Simultaneous events:
  - Hit and expiry on the same hole in the same cycle: hit wins, no escape.
  - Spawn and hit in the same cycle: spawn judged on pre-edge moles, so it cannot target the hole being hit.
  - Round end on the same cycle as a hit: the hit scores, then moles clear.
  - start and tick on the same cycle in OVER: the round starts and that tick is not counted.

Decomposition:
- Package wam_pkg:
  - NUM_HOLES=9, KEY_W=4.
  - FSM encoding: IDLE=2'd0, PLAY=2'd1, OVER=2'd2.
  - LFSR tap mask.
- Sub-module wam_lfsr: 8-bit Fibonacci LFSR with seed parameter, synchronous reset, output lfsr[7:0].
- Per-hole life counters as a generate loop in the top.

Test Plan:
- Reset, then start=1 for 1 clk -> playing=1, time_left=GAME_TICKS, score=0, moles=0.
- Spawn and hit: SPAWN_GAP=2, LFSR_SEED such that c=4; after 2 ticks moles=9'h010. Then valid_key=1, key=4 -> next cycle moles=0, score=1, hit_pulse for exactly 1 clk. valid_key held high with same key -> no second hit.
- Escape: MOLE_LIFE=3, no key presses -> mole lowers on 3rd tick after spawn, misses=1, miss_pulse 1 clk.
- Whiff and invalid key: key=7 on an empty hole -> misses+1. key=12 -> no change.
- MAX_ACTIVE=1 with continuous spawns -> popcount(moles) never exceeds 1. Hit and expiry in the same cycle -> score+1, misses unchanged.
- Round end and reset: GAME_TICKS=5 -> game_over after 5th tick, moles=0, score held; start -> new round with score=0. reset asserted mid-PLAY -> IDLE, all outputs 0 next cycle.
